// File: rtl/hash_serdes_pkg.sv
// Shared constants, state encoding and mode lookup helpers for the digest serializer.
package hash_serdes_pkg;

    localparam int unsigned DOUT_W         = 1344;
    localparam int unsigned BEAT_W         = 64;
    localparam int unsigned KEEP_W         = BEAT_W / 8;
    localparam int unsigned CNT_W          = 5;
    localparam int unsigned MODE_W         = 4;
    localparam int unsigned ALGO_SHAKE_BIT = 3;

    localparam logic [MODE_W-1:0] MODE_SHAKE128 = 4'b1000;
    localparam logic [MODE_W-1:0] MODE_SHAKE256 = 4'b1001;
    localparam logic [MODE_W-1:0] MODE_SHA3_256 = 4'b1010;
    localparam logic [MODE_W-1:0] MODE_SHA3_512 = 4'b1011;
    localparam logic [MODE_W-1:0] MODE_SHA3_224 = 4'b1100;
    localparam logic [MODE_W-1:0] MODE_SHA3_384 = 4'b1101;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    // Number of 64-bit beats in the digest; zero marks an unsupported mode.
    function automatic logic [CNT_W-1:0] digest_beats(input logic [MODE_W-1:0] mode);
        logic [CNT_W-1:0] beats;
        beats = '0;
        if (!mode[ALGO_SHAKE_BIT]) begin
            beats = mode[0] ? CNT_W'(8) : CNT_W'(4);
        end else begin
            case (mode)
                MODE_SHAKE128: beats = CNT_W'(21);
                MODE_SHAKE256: beats = CNT_W'(17);
                MODE_SHA3_256: beats = CNT_W'(4);
                MODE_SHA3_512: beats = CNT_W'(8);
                MODE_SHA3_224: beats = CNT_W'(4);
                MODE_SHA3_384: beats = CNT_W'(6);
                default:       beats = '0;
            endcase
        end
        return beats;
    endfunction

    // Byte-enable pattern for the final beat; only SHA3-224 ends mid-word.
    function automatic logic [KEEP_W-1:0] last_keep(input logic [MODE_W-1:0] mode);
        logic [KEEP_W-1:0] keep;
        keep = '1;
        if (mode == MODE_SHA3_224) begin
            keep = KEEP_W'(8'hF0);
        end
        return keep;
    endfunction

endpackage

// File: rtl/hash_digest_shreg.sv
// Digest holding register: parallel load, shift-left by one beat, remaining-beat counter.
module hash_digest_shreg
    import hash_serdes_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic              shift,
    input  logic [DOUT_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_beats,
    output logic [BEAT_W-1:0] head,
    output logic [CNT_W-1:0]  remaining,
    output logic [CNT_W-1:0]  remaining_nxt_c
);

    logic [DOUT_W-1:0] sreg;

    // Next counter value, exported so the top can register tlast/tkeep in step.
    always_comb begin
        remaining_nxt_c = remaining;
        if (load) begin
            remaining_nxt_c = load_beats;
        end else if (shift && (remaining != '0)) begin
            remaining_nxt_c = remaining - CNT_W'(1);
        end
    end

    // Load wins over shift so a back-to-back capture replaces the old digest.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sreg      <= '0;
            remaining <= '0;
        end else begin
            if (load) begin
                sreg <= load_data;
            end else if (shift) begin
                sreg <= {sreg[DOUT_W-BEAT_W-1:0], BEAT_W'(0)};
            end
            remaining <= remaining_nxt_c;
        end
    end

    assign head = sreg[DOUT_W-1 -: BEAT_W];

endmodule

// File: rtl/hash_digest_serializer.sv
// Captures a hash result and streams the mode-sized digest as 64-bit AXI-Stream beats.
module hash_digest_serializer
    import hash_serdes_pkg::*;
#(
    parameter int unsigned WORD_W = 64,
    parameter int unsigned ID_W   = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [3:0]        algo_mode,
    input  logic [DOUT_W-1:0] din,
    input  logic              din_valid,
    input  logic [ID_W-1:0]   din_id,
    output logic              din_ready,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [WORD_W-1:0] m_tdata,
    output logic [7:0]        m_tkeep,
    output logic              m_tlast,
    output logic [ID_W-1:0]   m_tid,
    output logic              ovf_o,
    output logic              err_mode_o,
    input  logic              clr_i
);

    state_t            state;
    state_t            state_d;
    logic              hs;
    logic              last_hs;
    logic              mode_ok;
    logic              load;
    logic              shift;
    logic              tlast_d;
    logic [7:0]        keep_d;
    logic [7:0]        last_keep_q;
    logic [CNT_W-1:0]  beats_mode;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  remaining_nxt;
    logic [BEAT_W-1:0] head;

    hash_digest_shreg u_shreg (
        .clk             (clk),
        .rstn            (rstn),
        .load            (load),
        .shift           (shift),
        .load_data       (din),
        .load_beats      (beats_mode),
        .head            (head),
        .remaining       (remaining),
        .remaining_nxt_c (remaining_nxt)
    );

    assign m_tdata = WORD_W'(head);

    // Next state, capture/shift strobes and next-cycle beat qualifiers.
    always_comb begin
        state_d    = state;
        din_ready  = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        hs         = m_tvalid & m_tready;
        last_hs    = hs & m_tlast;
        beats_mode = digest_beats(algo_mode);
        mode_ok    = (beats_mode != '0);
        case (state)
            ST_IDLE: begin
                din_ready = 1'b1;
                if (din_valid && mode_ok) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                shift = hs;
                if (last_hs) begin
                    din_ready = 1'b1;
                    if (din_valid && mode_ok) begin
                        load  = 1'b1;
                        shift = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tlast_d = (state_d == ST_SEND) && (remaining_nxt == CNT_W'(1));
        keep_d  = 8'h00;
        if (state_d == ST_SEND) begin
            if (!tlast_d) begin
                keep_d = 8'hFF;
            end else if (load) begin
                keep_d = last_keep(algo_mode);
            end else begin
                keep_d = last_keep_q;
            end
        end
    end

    // State register and registered stream qualifiers; tid only moves on a new capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            m_tkeep     <= 8'h00;
            m_tid       <= '0;
            last_keep_q <= 8'h00;
        end else begin
            state    <= state_d;
            m_tvalid <= (state_d == ST_SEND);
            m_tlast  <= tlast_d;
            m_tkeep  <= keep_d;
            if (load) begin
                m_tid       <= din_id;
                last_keep_q <= last_keep(algo_mode);
            end
        end
    end

    // Sticky error flags; a new set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf_o      <= 1'b0;
            err_mode_o <= 1'b0;
        end else begin
            if (din_valid && !din_ready) begin
                ovf_o <= 1'b1;
            end else if (clr_i) begin
                ovf_o <= 1'b0;
            end
            if (din_valid && din_ready && !mode_ok) begin
                err_mode_o <= 1'b1;
            end else if (clr_i) begin
                err_mode_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hash_digest_serializer.sv
// Bench for hash_digest_serializer: mode table plus hand-written corner sequences.
module tb_hash_digest_serializer;

    localparam int unsigned DW = 1344;

    logic           clk = 1'b0;
    logic           rstn;
    logic [3:0]     algo_mode;
    logic [DW-1:0]  din;
    logic           din_valid;
    logic [31:0]    din_id;
    logic           din_ready;
    logic           m_tvalid;
    logic           m_tready;
    logic [63:0]    m_tdata;
    logic [7:0]     m_tkeep;
    logic           m_tlast;
    logic [31:0]    m_tid;
    logic           ovf_o;
    logic           err_mode_o;
    logic           clr_i;

    hash_digest_serializer dut (
        .clk        (clk),
        .rstn       (rstn),
        .algo_mode  (algo_mode),
        .din        (din),
        .din_valid  (din_valid),
        .din_id     (din_id),
        .din_ready  (din_ready),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tlast    (m_tlast),
        .m_tid      (m_tid),
        .ovf_o      (ovf_o),
        .err_mode_o (err_mode_o),
        .clr_i      (clr_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [31:0] id;
    } beat_t;

    typedef struct {
        string      name;
        logic [3:0] mode;
        int         beats;
        logic [7:0] lkeep;
    } vec_t;

    beat_t  q[$];
    vec_t   vecs[10];
    int     tests = 0;
    int     fails = 0;
    int     beats_seen = 0;
    logic [255:0] abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    function automatic logic [DW-1:0] rand_din();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one capture pulse (called at posedge+1); optionally queue the expected beats.
    task automatic capture(input logic [3:0] mode, input logic [DW-1:0] data, input logic [31:0] id,
                           input int nb, input logic [7:0] lk);
        beat_t b;
        algo_mode = mode;
        din       = data;
        din_id    = id;
        din_valid = 1'b1;
        for (int i = 0; i < nb; i++) begin
            b.data = data[DW-1-64*i -: 64];
            b.last = (i == nb - 1);
            b.keep = b.last ? lk : 8'hFF;
            b.id   = id;
            q.push_back(b);
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        algo_mode = 4'($urandom);
        din       = rand_din();
        din_id    = $urandom;
    endtask

    // Wait for the scoreboard to empty, optionally toggling tready each cycle.
    task automatic drain(input string nm, input bit toggle);
        for (int c = 0; c < 300 && q.size() != 0; c++) begin
            @(posedge clk); #1;
            if (toggle) m_tready = ~m_tready;
        end
        m_tready = 1'b1;
        check({nm, "_drained"}, 64'(q.size()), 64'd0);
        q.delete();
        check({nm, "_idle_after"}, 64'(m_tvalid), 64'd0);
    endtask

    // Negedge sampler: stall stability and scoreboard pops on handshakes.
    task automatic monitor();
        logic  stall;
        beat_t prev;
        beat_t cur;
        beat_t exp;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall = 1'b0;
                continue;
            end
            cur = '{data: m_tdata, keep: m_tkeep, last: m_tlast, id: m_tid};
            if (stall) begin
                tests++;
                if (!m_tvalid || cur !== prev) begin
                    fails++;
                    $display("FAIL stall_stable: got valid=%b %h, expected valid=1 %h", m_tvalid, cur, prev);
                end
            end
            if (m_tvalid && m_tready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %h, expected no beat", cur);
                end else begin
                    exp = q.pop_front();
                    if (cur !== exp) begin
                        fails++;
                        $display("FAIL beat: got data=%h keep=%h last=%b id=%h, expected data=%h keep=%h last=%b id=%h",
                                 cur.data, cur.keep, cur.last, cur.id, exp.data, exp.keep, exp.last, exp.id);
                    end
                end
                beats_seen++;
            end
            stall = m_tvalid && !m_tready;
            prev  = cur;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        int base;
        vecs[0] = '{"sha256",      4'b0000, 4,  8'hFF};
        vecs[1] = '{"sha256_ign",  4'b0110, 4,  8'hFF};
        vecs[2] = '{"sha512",      4'b0001, 8,  8'hFF};
        vecs[3] = '{"sha512_ign",  4'b0111, 8,  8'hFF};
        vecs[4] = '{"shake128",    4'b1000, 21, 8'hFF};
        vecs[5] = '{"shake256",    4'b1001, 17, 8'hFF};
        vecs[6] = '{"sha3_256",    4'b1010, 4,  8'hFF};
        vecs[7] = '{"sha3_512",    4'b1011, 8,  8'hFF};
        vecs[8] = '{"sha3_224",    4'b1100, 4,  8'hF0};
        vecs[9] = '{"sha3_384",    4'b1101, 6,  8'hFF};

        rstn = 1'b0; algo_mode = 4'd0; din = '0; din_valid = 1'b0; din_id = '0;
        m_tready = 1'b0; clr_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", 64'(din_ready), 64'd1);
        check("rst_tvalid",    64'(m_tvalid),  64'd0);
        check("rst_tlast",     64'(m_tlast),   64'd0);
        check("rst_tkeep",     64'(m_tkeep),   64'd0);
        check("rst_tdata",     m_tdata,        64'd0);
        check("rst_tid",       64'(m_tid),     64'd0);
        check("rst_ovf",       64'(ovf_o),     64'd0);
        check("rst_err",       64'(err_mode_o), 64'd0);
        rstn = 1'b1;
        m_tready = 1'b1;
        fork monitor(); join_none
        @(posedge clk); #1;

        // Mode table, tready held high.
        for (int v = 0; v < 10; v++) begin
            capture(vecs[v].mode, rand_din(), $urandom, vecs[v].beats, vecs[v].lkeep);
            check({vecs[v].name, "_first_valid"}, 64'(m_tvalid), 64'd1);
            drain(vecs[v].name, 1'b0);
        end

        // SHA-256 of "abc".
        d = rand_din();
        d[DW-1 -: 256] = abc;
        capture(4'b0000, d, 32'hA0A0_0001, 4, 8'hFF);
        check("abc_beat0", m_tdata, 64'hba7816bf8f01cfea);
        drain("abc", 1'b0);

        // SHAKE128 with tready toggling.
        m_tready = 1'b0;
        capture(4'b1000, rand_din(), 32'h5EED_0128, 21, 8'hFF);
        drain("shake128_toggle", 1'b1);

        // Back-to-back capture on the SHA-512 tlast handshake.
        capture(4'b0001, rand_din(), 32'hB2B0_0001, 8, 8'hFF);
        for (int c = 0; c < 20 && !(m_tvalid && m_tlast); c++) begin
            @(posedge clk); #1;
        end
        check("b2b_ready_on_last", 64'(din_ready), 64'd1);
        d = rand_din();
        capture(4'b1010, d, 32'hB2B0_0002, 4, 8'hFF);
        check("b2b_no_bubble", 64'(m_tvalid), 64'd1);
        check("b2b_new_beat0", m_tdata, d[DW-1 -: 64]);
        drain("b2b", 1'b0);
        check("b2b_ovf", 64'(ovf_o), 64'd0);

        // Dropped pulse mid-digest.
        base = beats_seen;
        capture(4'b0001, rand_din(), 32'h0F0F_0001, 8, 8'hFF);
        for (int c = 0; c < 20 && beats_seen != base + 2; c++) begin
            @(posedge clk); #1;
        end
        algo_mode = 4'b0000; din = rand_din(); din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        drain("ovf_stream", 1'b0);
        check("ovf_set", 64'(ovf_o), 64'd1);
        check("ovf_no_err", 64'(err_mode_o), 64'd0);

        // Unsupported mode capture.
        algo_mode = 4'b1110; din = rand_din(); din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("err_no_valid", 64'(m_tvalid), 64'd0);
            @(posedge clk); #1;
        end
        check("err_set", 64'(err_mode_o), 64'd1);
        check("err_ready", 64'(din_ready), 64'd1);
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        check("clr_ovf", 64'(ovf_o), 64'd0);
        check("clr_err", 64'(err_mode_o), 64'd0);

        // Clear together with an unsupported capture: the set wins.
        algo_mode = 4'b1111; din_valid = 1'b1; clr_i = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0; clr_i = 1'b0;
        check("clr_vs_set_err", 64'(err_mode_o), 64'd1);
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;

        // Reset at beat 5 of SHAKE256.
        base = beats_seen;
        capture(4'b1001, rand_din(), 32'h7E57_0256, 17, 8'hFF);
        for (int c = 0; c < 30 && beats_seen != base + 5; c++) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0; m_tready = 1'b0;
        q.delete();
        @(posedge clk); #1;
        check("midrst_tvalid",    64'(m_tvalid),  64'd0);
        check("midrst_din_ready", 64'(din_ready), 64'd1);
        check("midrst_tlast",     64'(m_tlast),   64'd0);
        check("midrst_tkeep",     64'(m_tkeep),   64'd0);
        check("midrst_tdata",     m_tdata,        64'd0);
        check("midrst_tid",       64'(m_tid),     64'd0);
        rstn = 1'b1; m_tready = 1'b1;
        @(posedge clk); #1;
        d = rand_din();
        d[DW-1 -: 256] = abc;
        capture(4'b0000, d, 32'hA0A0_0002, 4, 8'hFF);
        check("post_rst_beat0", m_tdata, 64'hba7816bf8f01cfea);
        drain("post_rst", 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
